// File: rtl/pic_priority_scheduler.sv
// 8259A-style interrupt scheduler: IRR/ISR, rotating fully nested priority, INTA sequencing, OCW2 EOI.
// Optional build macro SPECIAL_MASK_EN adds the SMM input (special mask mode).
module pic_priority_scheduler #(
    parameter int NUM_IR   = 8,
    parameter int RESET_LP = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_IR-1:0] IR,
    input  logic [NUM_IR-1:0] IMR,
    input  logic              LTIM,
    input  logic              AEOI,
    input  logic              INTA,
    input  logic              EOI_VALID,
    input  logic [2:0]        EOI_CMD,
    input  logic [2:0]        EOI_LEVEL,
`ifdef SPECIAL_MASK_EN
    input  logic              SMM,
`endif
    output logic              INT,
    output logic [2:0]        INT_VEC,
    output logic              VEC_VALID,
    output logic [NUM_IR-1:0] IRR,
    output logic [NUM_IR-1:0] ISR
);

    typedef enum logic [1:0] {S_IDLE, S_ACK1, S_WAIT2, S_ACK2} state_t;

    state_t      r_state;
    logic [7:0]  r_irr, r_isr, r_ir_q;
    logic        r_inta_q, r_rotate_aeoi, r_int, r_vec_valid, r_spurious;
    logic [2:0]  r_lp, r_int_vec;

    logic        w_fall, w_ack1, w_aeoi_done, w_cand_ok, w_top_ok, w_eoi_lp_we;
    logic [2:0]  w_base, w_cand, w_top, w_eoi_lp;
    logic [7:0]  w_req, w_blk, w_req_rot, w_blk_rot, w_allow;
    logic [7:0]  w_ack_set, w_eoi_clr, w_aeoi_clr, w_irr_nxt, w_isr_nxt;

    // Rotated view: bit k of the result is level (k + sh) mod 8, so bit 0 is the highest priority.
    function automatic logic [7:0] rot_dn(input logic [7:0] v, input logic [2:0] sh);
        return 8'(({v, v} >> sh));
    endfunction

    function automatic logic [3:0] pick_first(input logic [7:0] rv, input logic [2:0] base);
        pick_first = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rv[k]) pick_first = {1'b1, 3'(k) + base};
        end
    endfunction

`ifdef SPECIAL_MASK_EN
    assign w_blk = SMM ? 8'h00 : r_isr;
    assign w_req = SMM ? (r_irr & ~IMR & ~r_isr) : (r_irr & ~IMR);
`else
    assign w_blk = r_isr;
    assign w_req = r_irr & ~IMR;
`endif

    assign w_base = r_lp + 3'd1;
    assign w_fall = r_inta_q & ~INTA;
    assign w_ack1 = (r_state == S_IDLE) && w_fall;
    assign w_aeoi_done = (r_state == S_ACK2) && INTA && AEOI && !r_spurious;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_req_rot = rot_dn(w_req, w_base);
        w_blk_rot = rot_dn(w_blk, w_base);
        w_allow   = 8'hFF;
        for (int k = 7; k >= 0; k--) begin
            if (w_blk_rot[k]) w_allow = ~(8'hFF << k);
        end
        {w_cand_ok, w_cand} = pick_first(w_req_rot & w_allow, w_base);
        {w_top_ok, w_top}   = pick_first(rot_dn(r_isr, w_base), w_base);

        w_eoi_clr   = 8'h00;
        w_eoi_lp_we = 1'b0;
        w_eoi_lp    = EOI_LEVEL;
        if (EOI_VALID) begin
            case (EOI_CMD)
                3'b001: if (w_top_ok) w_eoi_clr = 8'd1 << w_top;
                3'b011: w_eoi_clr = 8'd1 << EOI_LEVEL;
                3'b101: if (w_top_ok) begin
                    w_eoi_clr   = 8'd1 << w_top;
                    w_eoi_lp_we = 1'b1;
                    w_eoi_lp    = w_top;
                end
                3'b111: begin
                    w_eoi_clr   = 8'd1 << EOI_LEVEL;
                    w_eoi_lp_we = 1'b1;
                end
                3'b110: w_eoi_lp_we = 1'b1;
                default: ;
            endcase
        end

        w_ack_set  = (w_ack1 && w_cand_ok) ? (8'd1 << w_cand) : 8'h00;
        w_aeoi_clr = w_aeoi_done ? (8'd1 << r_int_vec) : 8'h00;
        // An acknowledge set beats any clear of the same bit.
        w_isr_nxt  = (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_ack_set;

        if (LTIM)
            w_irr_nxt = IR & ~w_ack_set;
        else
            w_irr_nxt = (r_irr | (IR & ~r_ir_q)) & ~w_ack_set
                        & ((r_state == S_ACK1) ? IR : 8'hFF);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_irr         <= 8'h00;
            r_isr         <= 8'h00;
            r_ir_q        <= 8'h00;
            r_inta_q      <= 1'b1;
            r_lp          <= 3'(RESET_LP);
            r_rotate_aeoi <= 1'b0;
            r_int         <= 1'b0;
            r_int_vec     <= 3'd0;
            r_vec_valid   <= 1'b0;
            r_spurious    <= 1'b0;
        end else begin
            // NOTE: all state updates are non-blocking so every branch sees pre-edge values.
            r_ir_q   <= IR;
            r_inta_q <= INTA;
            r_irr    <= w_irr_nxt;
            r_isr    <= w_isr_nxt;
            r_int    <= 1'b0;

            if (EOI_VALID && EOI_CMD == 3'b100) r_rotate_aeoi <= 1'b1;
            if (EOI_VALID && EOI_CMD == 3'b000) r_rotate_aeoi <= 1'b0;

            if (w_eoi_lp_we)
                r_lp <= w_eoi_lp;
            else if (w_aeoi_done && r_rotate_aeoi)
                r_lp <= r_int_vec;

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state    <= S_ACK1;
                        r_int_vec  <= w_cand_ok ? w_cand : 3'd7;
                        r_spurious <= !w_cand_ok;
                    end else begin
                        r_int <= w_cand_ok;
                    end
                end
                S_ACK1:  if (INTA) r_state <= S_WAIT2;
                S_WAIT2: if (w_fall) begin
                    r_state     <= S_ACK2;
                    r_vec_valid <= 1'b1;
                end
                S_ACK2:  if (INTA) begin
                    r_state     <= S_IDLE;
                    r_vec_valid <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign INT       = r_int;
    assign INT_VEC   = r_int_vec;
    assign VEC_VALID = r_vec_valid;
    assign IRR       = r_irr;
    assign ISR       = r_isr;

endmodule

// File: tb/tb_pic_priority_scheduler.sv
// Self-checking bench for pic_priority_scheduler: directed scenarios then randomized traffic vs a rank-based model.
module tb_pic_priority_scheduler;

    logic       CLK = 1'b0;
    logic       rst, ltim, aeoi, inta, eoi_valid;
    logic [7:0] ir, imr;
    logic [2:0] eoi_cmd, eoi_level;
    logic       INT, VEC_VALID;
    logic [2:0] INT_VEC;
    logic [7:0] IRR, ISR;
`ifdef SPECIAL_MASK_EN
    logic       smm = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit [7:0] m_irr, m_isr, m_ir_q;
    bit       m_inta_q, m_rot, m_int, m_vv, m_spur;
    int       m_lp, m_phase, m_vec;

    always #5 CLK = ~CLK;

    pic_priority_scheduler #(.NUM_IR(8), .RESET_LP(7)) dut (
        .CLK(CLK), .RST(rst), .IR(ir), .IMR(imr), .LTIM(ltim), .AEOI(aeoi),
        .INTA(inta), .EOI_VALID(eoi_valid), .EOI_CMD(eoi_cmd), .EOI_LEVEL(eoi_level),
`ifdef SPECIAL_MASK_EN
        .SMM(smm),
`endif
        .INT(INT), .INT_VEC(INT_VEC), .VEC_VALID(VEC_VALID), .IRR(IRR), .ISR(ISR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Rank 0 is the highest priority; LP itself has rank 7.
    function automatic int rank_of(int lvl);
        return (lvl + 7 - m_lp) % 8;
    endfunction

    function automatic int best_of(bit [7:0] v);
        int b;
        b = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (b < 0 || rank_of(i) < rank_of(b))) b = i;
        return b;
    endfunction

    function automatic int model_candidate();
        int top, limit, c;
        top   = best_of(m_isr);
        limit = (top < 0) ? 8 : rank_of(top);
        c     = -1;
        for (int i = 0; i < 8; i++)
            if (m_irr[i] && !imr[i] && rank_of(i) < limit && (c < 0 || rank_of(i) < rank_of(c)))
                c = i;
        return c;
    endfunction

    task automatic model_step();
        bit       fall, second_done;
        int       cand, top, lp_eoi, n_lp;
        bit [7:0] ack_bit, eoi_clr, aeoi_clr, n_irr;
        if (rst) begin
            m_irr = 0; m_isr = 0; m_ir_q = 0; m_inta_q = 1; m_lp = 7; m_rot = 0;
            m_phase = 0; m_int = 0; m_vec = 0; m_vv = 0; m_spur = 0;
            return;
        end
        fall = m_inta_q && !inta;
        cand = model_candidate();
        top  = best_of(m_isr);
        ack_bit = 0;
        if (m_phase == 0 && fall && cand >= 0) ack_bit[cand] = 1;

        if (ltim) n_irr = ir & ~ack_bit;
        else begin
            n_irr = m_irr | (ir & ~m_ir_q);
            if (m_phase == 1) n_irr &= ir;
            n_irr &= ~ack_bit;
        end

        eoi_clr = 0; lp_eoi = -1;
        if (eoi_valid) begin
            case (eoi_cmd)
                3'd1: if (top >= 0) eoi_clr[top] = 1;
                3'd3: eoi_clr[eoi_level] = 1;
                3'd5: if (top >= 0) begin eoi_clr[top] = 1; lp_eoi = top; end
                3'd7: begin eoi_clr[eoi_level] = 1; lp_eoi = int'(eoi_level); end
                3'd6: lp_eoi = int'(eoi_level);
                default: ;
            endcase
        end

        aeoi_clr = 0; n_lp = m_lp;
        second_done = (m_phase == 3) && inta;
        if (second_done && aeoi && !m_spur) begin
            aeoi_clr[m_vec] = 1;
            if (m_rot) n_lp = m_vec;
        end
        if (lp_eoi >= 0) n_lp = lp_eoi;
        if (eoi_valid && eoi_cmd == 3'd4) m_rot = 1;
        if (eoi_valid && eoi_cmd == 3'd0) m_rot = 0;

        m_isr = (m_isr & ~(eoi_clr | aeoi_clr)) | ack_bit;
        m_irr = n_irr;
        m_int = 0;
        case (m_phase)
            0: if (fall) begin
                   m_phase = 1;
                   m_vec   = (cand >= 0) ? cand : 7;
                   m_spur  = (cand < 0);
               end else m_int = (cand >= 0);
            1: if (inta) m_phase = 2;
            2: if (fall) begin m_phase = 3; m_vv = 1; end
            default: if (inta) begin m_phase = 0; m_vv = 0; end
        endcase
        m_lp = n_lp;
        m_ir_q = ir;
        m_inta_q = inta;
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check("int", INT, m_int);
        check("int_vec", INT_VEC, m_vec);
        check("vec_valid", VEC_VALID, m_vv);
        check("irr", IRR, m_irr);
        check("isr", ISR, m_isr);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ack(input logic [2:0] exp_vec);
        inta = 0; ticks(2);
        inta = 1; tick(); check("vv_wait2", VEC_VALID, 0); tick();
        inta = 0; tick(); check("vv_ack2", VEC_VALID, 1); check("ack_vec", INT_VEC, exp_vec); tick();
        inta = 1; tick(); check("vv_done", VEC_VALID, 0);
    endtask

    task automatic eoi(input logic [2:0] cmd, input logic [2:0] lvl);
        eoi_valid = 1; eoi_cmd = cmd; eoi_level = lvl; tick();
        eoi_valid = 0; tick();
    endtask

    initial begin
        rst = 1; ir = 0; imr = 0; ltim = 0; aeoi = 0; inta = 1;
        eoi_valid = 0; eoi_cmd = 0; eoi_level = 0;
        ticks(2);
        check("rst_irr", IRR, 8'h00); check("rst_isr", ISR, 8'h00); check("rst_int", INT, 0);
        rst = 0; tick();

        // Basic edge-triggered acknowledge of IR2
        ir = 8'h04; tick(); check("s1_irr", IRR, 8'h04);
        tick(); check("s1_int", INT, 1);
        ack(3'd2); check("s1_isr", ISR, 8'h04);

        // Nesting: IR5 blocked by IR2 in service, IR0 preempts
        ir = 8'h24; ticks(2); check("s2_int_blocked", INT, 0);
        ir = 8'h25; ticks(2); check("s2_int_nest", INT, 1);
        ack(3'd0); check("s2_isr_nested", ISR, 8'h05);
        eoi(3'b001, 3'd0); check("s2_isr_eoi", ISR, 8'h04);
        eoi(3'b011, 3'd2); ticks(2);
        ack(3'd5); eoi(3'b001, 3'd0);

        // Automatic EOI, then rotation on AEOI
        aeoi = 1; ir = 8'h00; tick();
        ir = 8'h08; ticks(2); ack(3'd3); check("s3_isr_aeoi", ISR, 8'h00);
        eoi(3'b100, 3'd0);
        ir = 8'h00; tick(); ir = 8'h08; ticks(2); ack(3'd3);
        ir = 8'h00; tick(); ir = 8'h11; ticks(2); ack(3'd4);
        ack(3'd0);
        eoi(3'b000, 3'd0); aeoi = 0; ir = 8'h00; tick();

        // Set-priority command
        eoi(3'b110, 3'd5);
        ir = 8'h41; ticks(2); ack(3'd6);
        eoi(3'b001, 3'd0); ticks(2); ack(3'd0);
        eoi(3'b001, 3'd0); ir = 8'h00; tick();

        // Mask applied between INT and acknowledge -> spurious
        ir = 8'h02; ticks(2); check("s5_int", INT, 1);
        imr = 8'h02; tick(); ack(3'd7); check("s5_isr_spur", ISR, 8'h00);
        imr = 8'h00; ticks(2); ack(3'd1); eoi(3'b001, 3'd0); ir = 8'h00; tick();

        // Level mode, then reset in the middle of the second pulse
        ltim = 1; ir = 8'h80; tick(); check("s6_irr", IRR, 8'h80);
        tick(); ack(3'd7); check("s6_isr", ISR, 8'h80);
        eoi(3'b011, 3'd7); check("s6_irr_again", IRR, 8'h80); check("s6_isr_clr", ISR, 8'h00);
        tick(); check("s6_int_again", INT, 1);
        inta = 0; ticks(2); inta = 1; ticks(2); inta = 0; tick();
        check("s6_vv_pre_rst", VEC_VALID, 1);
        rst = 1; inta = 1; tick();
        check("s6_vv_rst", VEC_VALID, 0); check("s6_isr_rst", ISR, 8'h00);
        rst = 0; ltim = 0; ir = 8'h00; tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) ir[b] = ~ir[b];
            if ($urandom_range(0, 2) == 0) inta = ~inta;
            eoi_valid = ($urandom_range(0, 7) == 0);
            eoi_cmd   = 3'($urandom);
            eoi_level = 3'($urandom);
            if ($urandom_range(0, 99) == 0) imr = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 199) == 0) ltim = 1'($urandom);
            if ($urandom_range(0, 199) == 0) aeoi = 1'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pic_priority_scheduler.md
Name: pic_priority_scheduler

Overview:
- Clocked interrupt scheduler for the 8259A PIC, sitting between the IR pins, the ControlLogic register file (IMR, LTIM, AEOI, OCW2) and the INTA bus cycle.
- Holds IRR and ISR and resolves the highest-priority pending request under fully nested rules with a rotating priority pointer.
- Drives INT and sequences the two-pulse INTA acknowledge, presenting the 3-bit level for vector assembly (vector = {T7_T3, INT_VEC}).
- Executes EOI/rotation commands decoded from OCW2.

Parameters:
NUM_IR, 8, number of interrupt levels; fixed at 8, level index width 3.
RESET_LP, 7, lowest-priority level after reset (IR0 highest).

Ports:
CLK  input  1  system clock
RST  input  1  synchronous active-high reset
IR  input  8  interrupt request pins, synchronous to CLK
IMR  input  8  interrupt mask, 1 = masked
LTIM  input  1  1 = level-triggered, 0 = edge-triggered
AEOI  input  1  1 = automatic EOI at end of second INTA pulse
INTA  input  1  active-low acknowledge, synchronous to CLK
EOI_VALID  input  1  one-cycle strobe: OCW2 command present
EOI_CMD  input  3  OCW2 bits {R,SL,EOI}
EOI_LEVEL  input  3  OCW2 bits L2..L0
INT  output  1  interrupt request to CPU
INT_VEC  output  3  acknowledged level, valid while VEC_VALID
VEC_VALID  output  1  high during second INTA low phase
IRR  output  8  interrupt request register
ISR  output  8  in-service register

Behaviour:
- Clocking: one clock CLK; reset RST is synchronous, active-high. Reset values: IRR=0, ISR=0, IR_q=0, INTA_q=1, LP=RESET_LP, rotate_aeoi=0, state=IDLE, INT=0, INT_VEC=0, VEC_VALID=0. Reset mid-cycle aborts any acknowledge; no vector is issued.
- Request capture:
  - Edge mode: IRR[i] sets on IR[i] & ~IR_q[i]; it remains set until acknowledged or until IR[i] is low during ACK1.
  - Level mode: IRR[i] = IR[i] each cycle, except a bit cleared at ACK1 stays cleared for that cycle.
  - IR_q registers IR every cycle.
- Priority: level (LP+1) mod 8 is highest, LP is lowest, wrap-around modulo 8.
  - Candidate = highest-priority bit of IRR & ~IMR that is strictly higher than the highest-priority ISR bit.
  - INT is registered; INT=1 next cycle whenever a candidate exists and state=IDLE.
- FSM states: IDLE, ACK1, WAIT2, ACK2. Falling edge = INTA_q & ~INTA.
  - IDLE -> ACK1 on INTA falling edge.
    - With a candidate: ISR[c]=1, IRR[c]=0 (edge mode), INT_VEC=c, INT=0.
    - Without a candidate: spurious; INT_VEC=7, ISR unchanged.
  - ACK1 -> WAIT2 on INTA high.
  - WAIT2 -> ACK2 on next INTA falling edge; VEC_VALID=1 during ACK2.
  - ACK2 -> IDLE on INTA high; VEC_VALID=0 the same cycle.
    - If AEOI=1 and not spurious: clear ISR[INT_VEC].
    - If additionally rotate_aeoi=1: LP=INT_VEC.
  - Latency: INT_VEC is stable from the cycle after the first falling edge until return to IDLE.
- EOI commands, applied the cycle after the EOI_VALID strobe:
  - 001 non-specific EOI: clear highest-priority ISR bit.
  - 011 specific EOI: clear ISR[EOI_LEVEL].
  - 101 rotate on non-specific EOI: clear highest ISR bit b, LP=b.
  - 111 rotate on specific EOI: clear ISR[EOI_LEVEL], LP=EOI_LEVEL.
  - 110 set priority: LP=EOI_LEVEL, ISR unchanged.
  - 100: set rotate_aeoi. 000: clear rotate_aeoi. 010: no-op.
  - Non-specific EOI with ISR=0: no change, including LP.
- Simultaneous events:
  - EOI clear and ACK1 set on the same bit in one cycle: the set wins.
  - Other ISR bits are cleared independently.
  - EOI and AEOI clears in the same cycle are OR'd.
  - An LP update from EOI has priority over an LP update from AEOI rotation.
- Masking a candidate between INT and ACK1 causes a spurious acknowledge (INT_VEC=7).

Optional Feature:
SPECIAL_MASK_EN:
- With the macro defined: adds input SMM (1 bit). When SMM=1, ISR bits whose IMR bit is set do not block lower levels. The candidate is any unmasked IRR bit not in service, highest priority first.
- Without the macro: no SMM port; strict fully nested blocking always applies.

Test Plan:
- Reset, edge mode, IMR=0, IR=0x04 rising -> IRR=0x04, INT=1 next cycle; two INTA pulses -> ISR=0x04, INT_VEC=2, VEC_VALID high only in second low phase.
- ISR=0x04 held, IR5 edge -> INT stays 0; IR0 edge -> INT=1 (nesting); after ack ISR=0x05; EOI_CMD=001 -> ISR=0x04.
- AEOI=1, IR3 acked -> ISR returns to 0x00 on second INTA rise; with rotate_aeoi set (EOI_CMD=100) -> LP=3, IR4 then outranks IR0.
- EOI_CMD=110, EOI_LEVEL=5; IR=0x41 simultaneous -> first acknowledged INT_VEC=6, then 0 after EOI.
- IR1 pending, IMR set to 0x02 before first INTA -> INT_VEC=7, ISR unchanged (spurious).
- Level mode, IR7 held high, acknowledged, EOI 011 level 7 -> IRR=0x80 again and INT reasserts; RST mid-ACK2 -> VEC_VALID=0, ISR=0 next cycle.
